// File: rtl/reg_file_pkg.sv
// Shared constants for the register file slice: default geometry and clear-sequencer state encoding.
// Optional write-to-read bypass is enabled with REG_FILE_BYPASS_EN (see reg_file_rw).
package reg_file_pkg;
  localparam int DWIDTH_DEF = 16;
  localparam int AWIDTH_DEF = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;
endpackage

// File: rtl/reg_clr_seq.sv
// Clear sequencer: on clr walks every register address once, issuing a zero-write per cycle.
// ready is decoded straight from the state register. Unaffected by REG_FILE_BYPASS_EN.
module reg_clr_seq
  import reg_file_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  output logic              ready_o,
  output logic              clr_we_o,
  output logic [AWIDTH-1:0] clr_addr_o
);
  localparam int NREGS = 2**AWIDTH;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_we_o   = 1'b0;
    clr_addr_o = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        // clr is ignored here; counter wraps back to 0 on the last write
        clr_we_o = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == AWIDTH'(NREGS - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ready_o = (state_q == ST_IDLE);
endmodule

// File: rtl/reg_file_rw.sv
// 8x16 register file with two registered read ports, one write port and a sequenced clear.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data onto captured reads.
module reg_file_rw
  import reg_file_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_in,
  input  logic [AWIDTH-1:0] rd_addr,
  input  logic [AWIDTH-1:0] rs_addr,
  input  logic              we,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              clr,
  output logic [DWIDTH-1:0] rd_q,
  output logic [DWIDTH-1:0] rs_q,
  output logic              en_out,
  output logic              ready
);
  localparam int NREGS = 2**AWIDTH;

  logic [NREGS-1:0][DWIDTH-1:0] regs_q;
  logic                         seq_ready;
  logic                         clr_we;
  logic [AWIDTH-1:0]            clr_addr;
  logic                         wr_ok, rd_ok;
  logic [DWIDTH-1:0]            rd_d, rs_d;

  reg_clr_seq #(.AWIDTH(AWIDTH)) u_clr_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .ready_o    (seq_ready),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  assign ready = seq_ready;
  // A clr in the same IDLE cycle wins over the write; reads still see pre-clear data
  assign wr_ok = we & seq_ready & ~clr;
  assign rd_ok = en_in & seq_ready;

  always_comb begin
    rd_d = regs_q[rd_addr];
    rs_d = regs_q[rs_addr];
`ifdef REG_FILE_BYPASS_EN
    if (wr_ok && (wr_addr == rd_addr)) rd_d = wr_data;
    if (wr_ok && (wr_addr == rs_addr)) rs_d = wr_data;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else if (clr_we) begin
      regs_q[clr_addr] <= '0;
    end else if (wr_ok) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q   <= '0;
      rs_q   <= '0;
      en_out <= 1'b0;
    end else begin
      en_out <= rd_ok;
      if (rd_ok) begin
        rd_q <= rd_d;
        rs_q <= rs_d;
      end
    end
  end
endmodule

// File: tb/tb_reg_file_rw.sv
// Directed bench for reg_file_rw; expectations for the same-cycle read/write case follow REG_FILE_BYPASS_EN.
module tb_reg_file_rw;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_in, we, clr;
  logic [2:0]  rd_addr, rs_addr, wr_addr;
  logic [15:0] wr_data;
  logic [15:0] rd_q, rs_q;
  logic        en_out, ready;

  int n_chk  = 0;
  int n_fail = 0;
  int lowcnt;

  reg_file_rw dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_in   (en_in),
    .rd_addr (rd_addr),
    .rs_addr (rs_addr),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .clr     (clr),
    .rd_q    (rd_q),
    .rs_q    (rs_q),
    .en_out  (en_out),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    we = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic rdp(input logic [2:0] a, input logic [2:0] b);
    en_in = 1'b1; rd_addr = a; rs_addr = b;
    cyc();
    en_in = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 20) begin
      cyc();
      n++;
    end
    chk("wait_ready_timeout", 16'(ready), 16'd1);
  endtask

  initial begin
    rst_n = 1'b0; en_in = 1'b0; we = 1'b0; clr = 1'b0;
    rd_addr = '0; rs_addr = '0; wr_addr = '0; wr_data = '0;
    #12;
    chk("rst_ready", 16'(ready), 16'd1);
    chk("rst_en_out", 16'(en_out), 16'd0);
    chk("rst_rd_q", rd_q, 16'h0000);
    chk("rst_rs_q", rs_q, 16'h0000);
    rst_n = 1'b1;
    cyc();

    // 1: read after reset, then idle cycle holds data
    rdp(3'd2, 3'd5);
    chk("t1_en_out", 16'(en_out), 16'd1);
    chk("t1_rd_q", rd_q, 16'h0000);
    chk("t1_rs_q", rs_q, 16'h0000);
    cyc();
    chk("t1_idle_en_out", 16'(en_out), 16'd0);

    // 2: write two registers, read both back
    wr(3'd3, 16'hBEEF);
    wr(3'd4, 16'h1234);
    rdp(3'd3, 3'd4);
    chk("t2_en_out", 16'(en_out), 16'd1);
    chk("t2_rd_q", rd_q, 16'hBEEF);
    chk("t2_rs_q", rs_q, 16'h1234);
    cyc();
    chk("t2_hold_rd_q", rd_q, 16'hBEEF);
    chk("t2_hold_en_out", 16'(en_out), 16'd0);

    // 3: same-cycle write and read of r6
    wr(3'd6, 16'h0001);
    we = 1'b1; wr_addr = 3'd6; wr_data = 16'hA5A5;
    en_in = 1'b1; rd_addr = 3'd6; rs_addr = 3'd3;
    cyc();
    we = 1'b0; en_in = 1'b0;
`ifdef REG_FILE_BYPASS_EN
    chk("t3_rd_bypass", rd_q, 16'hA5A5);
`else
    chk("t3_rd_old", rd_q, 16'h0001);
`endif
    chk("t3_rs_q", rs_q, 16'hBEEF);
    rdp(3'd6, 3'd6);
    chk("t3_rd_new", rd_q, 16'hA5A5);
    chk("t3_rs_new", rs_q, 16'hA5A5);

    // 4: fill, clear, requests during clear are ignored
    for (int i = 0; i < 8; i++) wr(3'(i), 16'hFFFF);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    en_in = 1'b1; rd_addr = 3'd1; rs_addr = 3'd1;
    we = 1'b1; wr_addr = 3'd1; wr_data = 16'h7777;
    chk("t4_ready_low", 16'(ready), 16'd0);
    lowcnt = 1;
    while (!ready && lowcnt < 20) begin
      cyc();
      chk("t4_en_out_blocked", 16'(en_out), 16'd0);
      if (!ready) lowcnt++;
    end
    en_in = 1'b0; we = 1'b0;
    chk("t4_ready_low_cycles", 16'(lowcnt), 16'd8);
    for (int i = 0; i < 8; i++) begin
      rdp(3'(i), 3'(7 - i));
      chk("t4_rd_zero", rd_q, 16'h0000);
      chk("t4_rs_zero", rs_q, 16'h0000);
    end

    // 5a: clr with we in the same cycle drops the write
    we = 1'b1; wr_addr = 3'd2; wr_data = 16'h5555; clr = 1'b1;
    cyc();
    we = 1'b0; clr = 1'b0;
    wait_ready();
    rdp(3'd2, 3'd2);
    chk("t5_wr_dropped", rd_q, 16'h0000);

    // 5b: clr with en_in reads pre-clear data
    wr(3'd2, 16'h0042);
    en_in = 1'b1; rd_addr = 3'd2; rs_addr = 3'd2; clr = 1'b1;
    cyc();
    en_in = 1'b0; clr = 1'b0;
    chk("t5_en_out", 16'(en_out), 16'd1);
    chk("t5_rd_preclear", rd_q, 16'h0042);
    chk("t5_ready_low", 16'(ready), 16'd0);
    wait_ready();
    rdp(3'd2, 3'd2);
    chk("t5_rd_cleared", rd_q, 16'h0000);

    // 6: reset in the 4th cycle of a clear
    wr(3'd7, 16'h1357);
    rdp(3'd7, 3'd7);
    chk("t6_pre_rd_q", rd_q, 16'h1357);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    cyc(); cyc(); cyc();
    chk("t6_mid_clear_ready", 16'(ready), 16'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", 16'(ready), 16'd1);
    chk("t6_rst_en_out", 16'(en_out), 16'd0);
    chk("t6_rst_rd_q", rd_q, 16'h0000);
    chk("t6_rst_rs_q", rs_q, 16'h0000);
    #1 rst_n = 1'b1;
    cyc();
    rdp(3'd7, 3'd0);
    chk("t6_rd_r7_zero", rd_q, 16'h0000);
    chk("t6_rs_r0_zero", rs_q, 16'h0000);
    wr(3'd7, 16'h00FF);
    rdp(3'd7, 3'd7);
    chk("t6_rd_r7", rd_q, 16'h00FF);
    chk("t6_rs_r7", rs_q, 16'h00FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
